// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multicycle MIPS datapath
module multicycle_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RWB    = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ADDIEX = 4'd10,
      ADDIWB = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   state_t cur;
   state_t nxt;

   assign state = cur;

   // Next-state selection; op only steers the DECODE and MEMADR branches
   always_comb begin
      nxt = FETCH;
      case (cur)
         FETCH:  nxt = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: nxt = MEMADR;
               OP_RTYPE:     nxt = EXEC;
               OP_BEQ:       nxt = BRANCH;
               OP_J:         nxt = JUMP;
               OP_ADDI:      nxt = ADDIEX;
               default:      nxt = FETCH;
            endcase
         end
         MEMADR: nxt = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
         MEMWB:  nxt = FETCH;
         MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
         EXEC:   nxt = RWB;
         RWB:    nxt = FETCH;
         BRANCH: nxt = FETCH;
         JUMP:   nxt = FETCH;
         ADDIEX: nxt = ADDIWB;
         ADDIWB: nxt = FETCH;
         default: nxt = FETCH;
      endcase
   end

   // State register, cleared straight back to FETCH by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cur <= FETCH;
      else        cur <= nxt;
   end

   // Output decode of the current state; enables are forced low during reset
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      illegal_op  = 1'b0;
      case (cur)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         DECODE: begin
            ALUSrcB    = 2'b11;
            illegal_op = !(op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         RWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
         end
         JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
         end
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         ADDIWB: begin
            RegWrite = 1'b1;
         end
         default: begin
         end
      endcase
      if (!rst_n) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         RegWrite    = 1'b0;
         illegal_op  = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   logic       clk;
   logic       rst_n;
   logic [5:0] op;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;
   logic [16:0] act;

   int vectors;
   int miscompares;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
   );

   assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic legal(input logic [5:0] o);
      return (o == OP_RTYPE) || (o == OP_LW) || (o == OP_SW) ||
             (o == OP_BEQ) || (o == OP_J) || (o == OP_ADDI);
   endfunction

   // Expected control word for a state, straight from the per-state output table
   function automatic logic [16:0] exp_out(input int s, input logic mr,
                                           input logic [5:0] o, input logic rn);
      logic pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill;
      logic [1:0] srcb, aop, pcs;
      {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill} = '0;
      srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
      case (s)
         0:  begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
         1:  begin srcb = 2'b11; ill = !legal(o); end
         2:  begin srca = 1'b1; srcb = 2'b10; end
         3:  begin mrd = 1'b1; iord = 1'b1; end
         4:  begin rw = 1'b1; m2r = 1'b1; end
         5:  begin mwr = 1'b1; iord = 1'b1; end
         6:  begin srca = 1'b1; aop = 2'b10; end
         7:  begin rw = 1'b1; rdst = 1'b1; end
         8:  begin srca = 1'b1; aop = 2'b01; pcc = 1'b1; pcs = 2'b01; end
         9:  begin pcw = 1'b1; pcs = 2'b10; end
         10: begin srca = 1'b1; srcb = 2'b10; end
         11: begin rw = 1'b1; end
         default: begin end
      endcase
      if (!rn) {pcw, pcc, mrd, mwr, irw, rw, ill} = '0;
      return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs, ill};
   endfunction

   // Runs one instruction from FETCH through its last state; wf/wm are wait cycles
   task automatic run_instr(input logic [5:0] o, input int wf, input int wm);
      int route[$];
      int reps;
      int s;
      route = {0, 1};
      case (o)
         OP_LW:    route = {route, 2, 3, 4};
         OP_SW:    route = {route, 2, 5};
         OP_RTYPE: route = {route, 6, 7};
         OP_BEQ:   route = {route, 8};
         OP_J:     route = {route, 9};
         OP_ADDI:  route = {route, 10, 11};
         default:  begin end
      endcase
      foreach (route[i]) begin
         s = route[i];
         reps = (s == 0) ? wf : ((s == 3 || s == 5) ? wm : 0);
         for (int k = 0; k <= reps; k++) begin
            @(negedge clk);
            if (s == 0 || s == 3 || s == 5) mem_ready = (k == reps);
            else mem_ready = 1'($urandom);
            op = (s == 1 || s == 2) ? o : 6'($urandom);
            #1;
            vectors++;
            if (state !== 4'(s)) begin
               miscompares++;
               $display("FAIL state op=%b step=%0d: got %0d expected %0d", o, i, state, s);
            end
            vectors++;
            if (act !== exp_out(s, mem_ready, op, 1'b1)) begin
               miscompares++;
               $display("FAIL outputs op=%b state=%0d mr=%b: got %b expected %b",
                        o, s, mem_ready, act, exp_out(s, mem_ready, op, 1'b1));
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mem_ready = 1'b1;
      op = 6'($urandom);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_ready = (i != 1);
         #1;
         vectors++;
         if (state !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %0d expected 0", state);
         end
         vectors++;
         if (act !== exp_out(0, mem_ready, op, 1'b0)) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected %b", act, exp_out(0, mem_ready, op, 1'b0));
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b1;
      op = 6'h3f;
      #1;
      vectors++;
      if (act !== exp_out(0, 1'b1, op, 1'b1) || IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_fetch: got %b expected %b", act, exp_out(0, 1'b1, op, 1'b1));
      end
      @(negedge clk);
      #1;
      vectors++;
      if (state !== 4'd1 || illegal_op !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_decode: got state=%0d ill=%b expected state=1 ill=1", state, illegal_op);
      end
   endtask

   task automatic test_lw();
      run_instr(OP_LW, 0, 0);
   endtask

   task automatic test_sw_wait();
      run_instr(OP_SW, 0, 3);
   endtask

   task automatic test_rtype_beq();
      run_instr(OP_RTYPE, 0, 0);
      run_instr(OP_BEQ, 1, 0);
   endtask

   task automatic test_j_illegal();
      run_instr(OP_J, 0, 0);
      run_instr(6'b111111, 0, 0);
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      vectors++;
      if (state !== 4'd0 || illegal_op !== 1'b0) begin
         miscompares++;
         $display("FAIL illegal_return: got state=%0d ill=%b expected state=0 ill=0", state, illegal_op);
      end
      // consume the FETCH cycle that was stalled above
      run_instr(OP_ADDI, 0, 0);
   endtask

   task automatic test_reset_midinstr();
      int seq[3] = '{0, 1, 2};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_ready = 1'b1;
         op = OP_LW;
         #1;
         vectors++;
         if (state !== 4'(seq[i])) begin
            miscompares++;
            $display("FAIL midreset_pre: got %0d expected %0d", state, seq[i]);
         end
      end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      vectors++;
      if (state !== 4'd3 || MemRead !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset_memrd: got state=%0d MemRead=%b expected 3/1", state, MemRead);
      end
      #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (state !== 4'd0 || act !== exp_out(0, mem_ready, op, 1'b0)) begin
         miscompares++;
         $display("FAIL midreset_async: got state=%0d out=%b expected 0/%b",
                  state, act, exp_out(0, mem_ready, op, 1'b0));
      end
      mem_ready = 1'b1;
      @(posedge clk);
      #2;
      vectors++;
      if (state !== 4'd0 || MemRead !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_hold: got state=%0d MemRead=%b expected 0/0", state, MemRead);
      end
      rst_n = 1'b1;
      run_instr(OP_RTYPE, 0, 0);
   endtask

   task automatic test_random();
      logic [5:0] o;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(6))
            0: o = OP_RTYPE;
            1: o = OP_LW;
            2: o = OP_SW;
            3: o = OP_BEQ;
            4: o = OP_J;
            5: o = OP_ADDI;
            default: begin
               do o = 6'($urandom); while (legal(o));
            end
         endcase
         run_instr(o, $urandom_range(3), $urandom_range(3));
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      mem_ready = 1'b1;
      op = 6'd0;
      test_reset();
      test_lw();
      test_sw_wait();
      test_rtype_beq();
      test_j_illegal();
      test_reset_midinstr();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
